color_scra_ctrl: RTL and testbench

//  Sequencer for the 24-bit colour-scramble datapath. It owns the three 2-bit channel selects (SWR/SWG/SWB).

---
 rtl/color_scra_pkg.sv | 37 +++
 rtl/color_scra_ctrl_rise_detect.sv | 27 ++
 rtl/color_scra_ctrl.sv | 141 ++++++++++++++
 tb/tb_color_scra_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/color_scra_pkg.sv
// Shared types and constants for the colour-scramble select sequencer.
package color_scra_pkg;

    typedef enum logic [1:0] {
        CUR_R = 2'd0,
        CUR_G = 2'd1,
        CUR_B = 2'd2
    } cursor_t;

    typedef logic [1:0] chsel_t;

    localparam chsel_t SEL_ZERO = 2'd3;
    localparam int     NUM_PERM = 6;

    // The six RGB permutations, listed as {R, G, B} selects.
    localparam chsel_t PERM [6][3] = '{
        '{2'd0, 2'd1, 2'd2},
        '{2'd0, 2'd2, 2'd1},
        '{2'd1, 2'd0, 2'd2},
        '{2'd1, 2'd2, 2'd0},
        '{2'd2, 2'd0, 2'd1},
        '{2'd2, 2'd1, 2'd0}
    };

    // Successor of a permutation index, wrapping 5 -> 0.
    function automatic logic [2:0] perm_next(input logic [2:0] idx);
        return (idx >= 3'(NUM_PERM - 1)) ? 3'd0 : idx + 3'd1;
    endfunction

    // Table lookup guarded against the unused index codes 6 and 7.
    function automatic chsel_t perm_lookup(input logic [2:0] idx, input logic [1:0] ch);
        if (idx >= 3'(NUM_PERM) || ch == 2'd3)
            return SEL_ZERO;
        return PERM[idx][ch];
    endfunction

endpackage

// File: rtl/color_scra_ctrl_rise_detect.sv
// Rising-edge detector for an already synchronised button level.
// The first clock after reset only primes the history register, so a
// button held down through reset does not register as a press.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic rise
);

    logic btn_q;
    logic primed;

    // History register plus a one-shot flag marking the first post-reset cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_q  <= 1'b0;
            primed <= 1'b0;
        end else begin
            btn_q  <= in;
            primed <= 1'b1;
        end
    end

    assign rise = in & ~btn_q & primed;

endmodule

// File: rtl/color_scra_ctrl.sv
// Select sequencer for the 24-bit colour-scramble datapath: manual button
// editing or timed permutation stepping into a pending register, which is
// committed to the datapath selects only on frame start.
module color_scra_ctrl
    import color_scra_pkg::*;
#(
    parameter int AUTO_PERIOD = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_sel,
    input  logic       btn_inc,
    input  logic       auto_en,
    input  logic       frame_start,
    output logic [1:0] SWR,
    output logic [1:0] SWG,
    output logic [1:0] SWB,
    output logic [1:0] cursor,
    output logic       dirty
);

    localparam int             TW   = $clog2(AUTO_PERIOD);
    localparam logic [TW-1:0]  TMAX = TW'(AUTO_PERIOD - 1);

    logic          sel_rise;
    logic          inc_rise;
    cursor_t       cur_q;
    cursor_t       cur_d;
    chsel_t        pend   [3];
    chsel_t        pend_d [3];
    logic [2:0]    perm_idx;
    logic [2:0]    perm_d;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_d;
    logic          auto_q;
    logic          step;

    rise_detect u_sel_rise (
        .clk   (clk),
        .reset (reset),
        .in    (btn_sel),
        .rise  (sel_rise)
    );

    rise_detect u_inc_rise (
        .clk   (clk),
        .reset (reset),
        .in    (btn_inc),
        .rise  (inc_rise)
    );

    // Auto step fires only once the timer has run a full period inside auto mode.
    assign step = auto_en & auto_q & (timer == TMAX);

    // Cursor state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cur_q <= CUR_R;
        else
            cur_q <= cur_d;
    end

    // Cursor next state: R -> G -> B -> R on a select press, manual mode only.
    always_comb begin
        cur_d = cur_q;
        if (!auto_en && sel_rise) begin
            case (cur_q)
                CUR_R:   cur_d = CUR_G;
                CUR_G:   cur_d = CUR_B;
                default: cur_d = CUR_R;
            endcase
        end
    end

    // Timer and permutation index: restart on auto entry, hold when manual.
    always_comb begin
        timer_d = timer;
        perm_d  = perm_idx;
        if (auto_en) begin
            if (!auto_q) begin
                timer_d = '0;
            end else if (step) begin
                timer_d = '0;
                perm_d  = perm_next(perm_idx);
            end else begin
                timer_d = timer + TW'(1);
            end
        end
    end

    // Pending selects: load the next permutation on an auto step, otherwise
    // bump the channel under the cursor on an increment press (wraps 3 -> 0).
    always_comb begin
        pend_d = pend;
        if (step) begin
            pend_d[0] = perm_lookup(perm_next(perm_idx), 2'd0);
            pend_d[1] = perm_lookup(perm_next(perm_idx), 2'd1);
            pend_d[2] = perm_lookup(perm_next(perm_idx), 2'd2);
        end else if (!auto_en && inc_rise) begin
            case (cur_q)
                CUR_R:   pend_d[0] = pend[0] + 2'd1;
                CUR_G:   pend_d[1] = pend[1] + 2'd1;
                default: pend_d[2] = pend[2] + 2'd1;
            endcase
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend[0]  <= 2'd0;
            pend[1]  <= 2'd1;
            pend[2]  <= 2'd2;
            perm_idx <= 3'd0;
            timer    <= '0;
            auto_q   <= 1'b0;
        end else begin
            pend     <= pend_d;
            perm_idx <= perm_d;
            timer    <= timer_d;
            auto_q   <= auto_en;
        end
    end

    // Commit registers: take the pre-update pending value on frame start only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            SWR <= 2'd0;
            SWG <= 2'd1;
            SWB <= 2'd2;
        end else if (frame_start) begin
            SWR <= pend[0];
            SWG <= pend[1];
            SWB <= pend[2];
        end
    end

    assign cursor = cur_q;
    assign dirty  = (pend[0] != SWR) || (pend[1] != SWG) || (pend[2] != SWB);

endmodule

// File: tb/tb_color_scra_ctrl.sv
// Directed self-checking bench for color_scra_ctrl with a short auto period.
module tb_color_scra_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_sel;
    logic       btn_inc;
    logic       auto_en;
    logic       frame_start;
    logic [1:0] SWR;
    logic [1:0] SWG;
    logic [1:0] SWB;
    logic [1:0] cursor;
    logic       dirty;

    int tests  = 0;
    int failed = 0;

    logic [5:0] perm_exp [6];
    logic [5:0] pend_now;

    color_scra_ctrl #(.AUTO_PERIOD(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_sel     (btn_sel),
        .btn_inc     (btn_inc),
        .auto_en     (auto_en),
        .frame_start (frame_start),
        .SWR         (SWR),
        .SWG         (SWG),
        .SWB         (SWB),
        .cursor      (cursor),
        .dirty       (dirty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Press and release buttons: rise seen on the first edge, release on the second.
    task automatic press(input logic s, input logic i);
        btn_sel = s;
        btn_inc = i;
        step();
        btn_sel = 1'b0;
        btn_inc = 1'b0;
        step();
    endtask

    task automatic frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    function automatic logic [5:0] pend_pack();
        return {dut.pend[0], dut.pend[1], dut.pend[2]};
    endfunction

    initial begin
        perm_exp[0] = 6'b00_10_01;
        perm_exp[1] = 6'b01_00_10;
        perm_exp[2] = 6'b01_10_00;
        perm_exp[3] = 6'b10_00_01;
        perm_exp[4] = 6'b10_01_00;
        perm_exp[5] = 6'b00_01_10;

        reset = 1'b1; btn_sel = 1'b0; btn_inc = 1'b0; auto_en = 1'b0; frame_start = 1'b0;
        step(); step();
        chk("rst_swr", SWR, 2'd0);
        chk("rst_swg", SWG, 2'd1);
        chk("rst_swb", SWB, 2'd2);
        chk("rst_cursor", cursor, 2'd0);
        chk("rst_dirty", dirty, 1'b0);
        reset = 1'b0;
        step(); step();

        // Manual edit of R: 0 -> 2, outputs untouched until frame start.
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        chk("inc2_pend_r", dut.pend[0], 2'd2);
        chk("inc2_dirty", dirty, 1'b1);
        chk("inc2_swr_hold", SWR, 2'd0);
        step(); step();
        chk("inc2_swr_still", SWR, 2'd0);
        frame();
        chk("commit_swr", SWR, 2'd2);
        chk("commit_dirty", dirty, 1'b0);

        // Cursor walk and B wrap.
        press(1'b1, 1'b0);
        chk("cursor_1", cursor, 2'd1);
        press(1'b1, 1'b0);
        chk("cursor_2", cursor, 2'd2);
        press(1'b0, 1'b1);
        chk("b_inc_3", dut.pend[2], 2'd3);
        press(1'b0, 1'b1);
        chk("b_wrap_0", dut.pend[2], 2'd0);
        chk("g_untouched", dut.pend[1], 2'd1);
        press(1'b1, 1'b0);
        chk("cursor_wrap_0", cursor, 2'd0);
        chk("wrap_dirty", dirty, 1'b1);

        // Simultaneous select and increment at cursor R.
        press(1'b1, 1'b1);
        chk("simul_pend_r", dut.pend[0], 2'd3);
        chk("simul_cursor", cursor, 2'd1);
        chk("simul_pend_g", dut.pend[1], 2'd1);

        // Drive everything to 3 and commit.
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        chk("all3_pend", {2'b00, pend_pack()}, 8'b00_11_11_11);
        frame();
        chk("all3_sw", {2'b00, SWR, SWG, SWB}, 8'b00_11_11_11);
        chk("all3_cursor", cursor, 2'd2);

        // Asynchronous reset mid-cycle, with inc held through reset.
        @(negedge clk);
        #2;
        reset = 1'b1;
        btn_inc = 1'b1;
        #1;
        chk("arst_sw", {2'b00, SWR, SWG, SWB}, 8'b00_00_01_10);
        chk("arst_cursor", cursor, 2'd0);
        chk("arst_dirty", dirty, 1'b0);
        chk("arst_pend", {2'b00, pend_pack()}, 8'b00_00_01_10);
        step();
        @(negedge clk);
        reset = 1'b0;
        step(); step(); step();
        chk("held_no_edge", dut.pend[0], 2'd0);
        btn_inc = 1'b0;
        step();

        // Frame start coinciding with an increment press.
        btn_inc = 1'b1;
        frame_start = 1'b1;
        step();
        btn_inc = 1'b0;
        frame_start = 1'b0;
        chk("coll_swr_old", SWR, 2'd0);
        chk("coll_pend_new", dut.pend[0], 2'd1);
        chk("coll_dirty", dirty, 1'b1);
        step();
        frame();
        chk("coll_commit", SWR, 2'd1);
        chk("coll_clean", dirty, 1'b0);

        // Auto mode: entry keeps pend, then a step every 4 cycles; buttons ignored.
        auto_en = 1'b1;
        btn_sel = 1'b1;
        btn_inc = 1'b1;
        step();
        btn_sel = 1'b0;
        btn_inc = 1'b0;
        step(); step(); step();
        chk("auto_entry_pend", {2'b00, pend_pack()}, 8'b00_01_01_10);
        chk("auto_entry_cursor", cursor, 2'd0);
        step();
        chk("auto_step1", {2'b00, pend_pack()}, {2'b00, perm_exp[0]});
        for (int k = 1; k < 6; k++) begin
            btn_sel = 1'b1;
            btn_inc = 1'b1;
            step();
            btn_sel = 1'b0;
            btn_inc = 1'b0;
            step(); step();
            pend_now = pend_pack();
            chk("auto_midperiod", {2'b00, pend_now}, {2'b00, perm_exp[k-1]});
            step();
            chk("auto_step", {2'b00, pend_pack()}, {2'b00, perm_exp[k]});
        end
        chk("auto_cursor_hold", cursor, 2'd0);
        frame();
        chk("auto_commit", {2'b00, SWR, SWG, SWB}, 8'b00_00_01_10);

        // Leaving auto: pend holds, buttons work again.
        step();
        auto_en = 1'b0;
        step(); step(); step(); step(); step();
        chk("manual_hold", {2'b00, pend_pack()}, 8'b00_00_01_10);
        press(1'b0, 1'b1);
        chk("manual_again", dut.pend[0], 2'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
